// File: rtl/select_reader.sv
// Purpose : burst read engine; walks start_len addresses from start_adr on a comb read port and streams the words out.
// Latency : read_adr loads on the start edge; the first word is valid after the next edge, then 1 word/cycle with out_ready high.
// Backpr. : 2-word buffer; fetching pauses while the buffer is full and not popping; head word is held stable while stalled.
// Option  : SELECT_READER_STRIDE_EN adds start_stride (address step, mod M); otherwise the step is 1.
module select_reader #(
    parameter int M = 128,
    parameter int W = 7,
    localparam int LOGM = (M > 1) ? $clog2(M) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LOGM-1:0] start_adr,
    input  logic [LOGM:0]   start_len,
`ifdef SELECT_READER_STRIDE_EN
    input  logic [LOGM-1:0] start_stride,
`endif
    output logic [LOGM-1:0] read_adr,
    input  logic [W-1:0]    read_data,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            done
);

    localparam logic [LOGM:0] M_W   = (LOGM+1)'(M);
    localparam logic [LOGM:0] ONE_W = (LOGM+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LOGM:0]   remaining;
    logic [1:0]      count;
    logic [W-1:0]    slot1_dat;
    logic            slot1_last;
    logic [LOGM-1:0] step;
    logic [LOGM:0]   adr_sum;
    logic [LOGM:0]   adr_nxt_full;
    logic            fetch;
    logic            pop;
    logic            accept;
    logic            done_nxt;
    logic            last_in;

    assign out_valid = (count != 2'd0);
    assign busy      = (state != IDLE);
    assign pop       = out_valid & out_ready;
    assign last_in   = (remaining == ONE_W);

`ifdef SELECT_READER_STRIDE_EN
    logic [LOGM:0] stride_full;

    // Reduce the requested stride into 0..M-1 (only one subtraction is ever needed).
    always_comb begin
        stride_full = {1'b0, start_stride};
        if (stride_full >= M_W) begin
            stride_full = stride_full - M_W;
        end
    end

    // Capture the stride together with the burst request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step <= '0;
        end else if (accept) begin
            step <= LOGM'(stride_full);
        end
    end
`else
    assign step = LOGM'(1);
`endif

    // Next read address: advance by the step and wrap modulo M.
    always_comb begin
        adr_sum      = {1'b0, read_adr} + {1'b0, step};
        adr_nxt_full = adr_sum;
        if (adr_sum >= M_W) begin
            adr_nxt_full = adr_sum - M_W;
        end
    end

    // Control: next state, fetch decision and done generation.
    always_comb begin
        state_nxt = state;
        fetch     = 1'b0;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if ((remaining != '0) && ((count != 2'd2) || pop)) begin
                    fetch = 1'b1;
                    if (last_in) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address walk, word counter and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_adr  <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= done_nxt;
            if (accept) begin
                read_adr  <= start_adr;
                remaining <= start_len;
            end else if (fetch) begin
                read_adr  <= LOGM'(adr_nxt_full);
                remaining <= remaining - ONE_W;
            end
        end
    end

    // Two-entry output buffer: head drives the outputs, slot1 holds the second word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= 2'd0;
            out_data   <= '0;
            out_last   <= 1'b0;
            slot1_dat  <= '0;
            slot1_last <= 1'b0;
        end else begin
            case ({fetch, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        out_data <= read_data;
                        out_last <= last_in;
                    end else begin
                        slot1_dat  <= read_data;
                        slot1_last <= last_in;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        out_data <= slot1_dat;
                        out_last <= slot1_last;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        out_data <= read_data;
                        out_last <= last_in;
                    end else begin
                        out_data   <= slot1_dat;
                        out_last   <= slot1_last;
                        slot1_dat  <= read_data;
                        slot1_last <= last_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_select_reader.sv
// Bench for select_reader: directed scenarios plus randomized bursts, checked by a scoreboard.
// Expected words come from a memory model walked with plain modular arithmetic.
// Define SELECT_READER_STRIDE_EN to also exercise the stride port.
module tb_select_reader;

    localparam int M    = 128;
    localparam int W    = 7;
    localparam int LOGM = 7;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } word_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [LOGM-1:0] start_adr = '0;
    logic [LOGM:0]   start_len = '0;
`ifdef SELECT_READER_STRIDE_EN
    logic [LOGM-1:0] start_stride = '0;
`endif
    logic [LOGM-1:0] read_adr;
    logic [W-1:0]    read_data;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_last;
    logic            busy;
    logic            done;

    logic [W-1:0] mem [M];
    word_t        exp_q[$];
    int           len_q[$];
    int           popped   = 0;
    int           checks   = 0;
    int           failures = 0;
    bit           rnd_rdy  = 1'b0;

    assign read_data = mem[read_adr];

    select_reader #(.M(M), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_adr    (start_adr),
        .start_len    (start_len),
`ifdef SELECT_READER_STRIDE_EN
        .start_stride (start_stride),
`endif
        .read_adr     (read_adr),
        .read_data    (read_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns at a posedge+1 point where busy is low, so start is sampled by the next edge.
    task automatic wait_idle();
        int n = 0;
        @(posedge clk); #1;
        while (busy && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    // Issue a burst and record what the memory should deliver for it.
    task automatic issue(input int adr, input int len);
        int step;
        int a;
        wait_idle();
`ifdef SELECT_READER_STRIDE_EN
        step = int'(start_stride) % M;
`else
        step = 1;
`endif
        start_adr = LOGM'(adr);
        start_len = (LOGM+1)'(len);
        start     = 1'b1;
        a = adr;
        for (int k = 0; k < len; k++) begin
            word_t w;
            w.d = mem[a];
            w.l = (k == len - 1);
            exp_q.push_back(w);
            a = (a + step) % M;
        end
        len_q.push_back(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Monitor: compare every transfer and every done pulse against the scoreboard.
    always @(negedge clk) begin
        word_t e;
        int    n;
        if (rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", int'(out_data), int'(e.d));
                    chk("word_last", int'(out_last), int'(e.l));
                end
                popped++;
            end
            if (done) begin
                if (len_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    n = len_q.pop_front();
                    chk("done_word_count", popped, n);
                end
                popped = 0;
            end
        end
    end

    // Random consumer backpressure when enabled.
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < M; i++) mem[i] = W'(i);

        // Reset state.
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_read_adr", int'(read_adr), 0);
        #10 rst = 1'b1;

        // Basic burst, latency and throughput.
        out_ready = 1'b1;
        issue(3, 4);
        @(negedge clk); chk("t2_valid_early", int'(out_valid), 0);
        @(negedge clk); chk("t2_first_valid", int'(out_valid), 1);
        chk("t2_first_data", int'(out_data), 3);
        @(negedge clk); chk("t2_valid_w1", int'(out_valid), 1);
        @(negedge clk); chk("t2_valid_w2", int'(out_valid), 1);
        @(negedge clk); chk("t2_last_data", int'(out_data), 6);
        chk("t2_last_flag", int'(out_last), 1);
        @(negedge clk); chk("t2_done", int'(done), 1);
        chk("t2_busy_drop", int'(busy), 0);

        // Address wrap.
        issue(126, 4);
        @(negedge clk); chk("t3_adr0", int'(read_adr), 126);
        @(negedge clk);
        @(negedge clk); chk("t3_adr_wrap", int'(read_adr), 0);

        // Backpressure: head held, fetch stalls with the buffer full.
        wait_idle();
        out_ready = 1'b0;
        issue(10, 5);
        @(negedge clk);
        @(negedge clk); chk("t4_valid", int'(out_valid), 1);
        chk("t4_data_first", int'(out_data), 10);
        @(negedge clk);
        @(negedge clk); chk("t4_data_held", int'(out_data), 10);
        chk("t4_adr_stall", int'(read_adr), 12);
        @(posedge clk); #1 out_ready = 1'b1;

        // Zero-length burst, then a start while busy must be ignored.
        issue(40, 0);
        @(negedge clk); chk("t5_done_len0", int'(done), 1);
        chk("t5_no_valid", int'(out_valid), 0);
        issue(50, 3);
        for (int k = 0; k < 2; k++) begin
            chk("t5_busy_poke", int'(busy), 1);
            start_adr = LOGM'($urandom_range(0, M - 1));
            start_len = (LOGM+1)'(5);
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end

`ifdef SELECT_READER_STRIDE_EN
        // Stride walk with wrap, and stride 0.
        start_stride = 7'd5;
        issue(120, 3);
        start_stride = 7'd0;
        issue(7, 3);
        wait_idle();
        start_stride = 7'd1;
`endif

        // Reset in the middle of a burst.
        issue(20, 10);
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t1_rst_valid", int'(out_valid), 0);
        chk("t1_rst_data", int'(out_data), 0);
        chk("t1_rst_last", int'(out_last), 0);
        chk("t1_rst_busy", int'(busy), 0);
        chk("t1_rst_done", int'(done), 0);
        chk("t1_rst_adr", int'(read_adr), 0);
        exp_q.delete();
        len_q.delete();
        popped = 0;
        #9 rst = 1'b1;
        @(negedge clk);
        chk("t1_post_busy", int'(busy), 0);
        chk("t1_post_done", int'(done), 0);

        // Randomized bursts with random backpressure.
        rnd_rdy = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int len;
            if (it % 8 == 7) begin
                wait_idle();
                for (int j = 0; j < 16; j++) mem[$urandom_range(0, M - 1)] = W'($urandom);
            end
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(100, M) : $urandom_range(0, 10);
`ifdef SELECT_READER_STRIDE_EN
            start_stride = LOGM'($urandom_range(0, M - 1));
`endif
            issue($urandom_range(0, M - 1), len);
        end
        wait_idle();
        rnd_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_words_left", exp_q.size(), 0);
        chk("end_bursts_left", len_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
